q_update_ctrl: RTL and testbench

//  Control unit that sequences one Q-learning update through the MII BRAM interface.
//  - Reads row Q(s,·), then row Q(s',·).
//  - Computes max/argmax over Q(s',·).
//  - Forms the TD update and issues one write of Q(s,a) via wen_cu.
//  - Sits between the agent top-level (start/done) and MII (S, A, Qnew, wen_cu).

---
 rtl/q_update_ctrl_pkg.sv | 21 ++
 rtl/q_update_ctrl_if.sv | 36 +++
 rtl/q_update_ctrl_argmax.sv | 25 ++
 rtl/q_update_ctrl.sv | 169 ++++++++++++++++
 tb/tb_q_update_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/q_update_ctrl_pkg.sv
// Shared definitions for the Q-learning update controller: FSM encoding,
// action count and default datapath widths.
package q_update_ctrl_pkg;

  localparam int unsigned N_ACT  = 4;
  localparam int unsigned QW_DEF = 16;
  localparam int unsigned SW_DEF = 12;

  // Guard bits so the TD sum cannot wrap before saturation.
  localparam int unsigned GUARD_BITS = 2;

  typedef enum logic [2:0] {
    StIdle,
    StRdCur,
    StRdNxt,
    StCalc,
    StWr,
    StDone
  } state_e;

endpackage

// File: rtl/q_update_ctrl_if.sv
// Agent/MII-facing signal bundle of the update controller.
// master = agent + memory side, slave = controller.
interface q_update_ctrl_if
  import q_update_ctrl_pkg::*;
#(
  parameter int unsigned Q_WIDTH = QW_DEF,
  parameter int unsigned S_WIDTH = SW_DEF,
  parameter int unsigned A_WIDTH = N_ACT
);

  logic                       start;
  logic [S_WIDTH-1:0]         s_cur;
  logic [S_WIDTH-1:0]         s_nxt;
  logic [A_WIDTH-1:0]         a_cur;
  logic signed [Q_WIDTH-1:0]  reward;
  logic [Q_WIDTH*N_ACT-1:0]   mem_Q;
  logic [S_WIDTH-1:0]         mem_S;
  logic [A_WIDTH-1:0]         mem_A;
  logic [Q_WIDTH-1:0]         mem_Qnew;
  logic                       mem_wen;
  logic [A_WIDTH-1:0]         q_max_a;
  logic                       busy;
  logic                       done;
  logic                       err;

  modport master (
    output start, s_cur, s_nxt, a_cur, reward, mem_Q,
    input  mem_S, mem_A, mem_Qnew, mem_wen, q_max_a, busy, done, err
  );

  modport slave (
    input  start, s_cur, s_nxt, a_cur, reward, mem_Q,
    output mem_S, mem_A, mem_Qnew, mem_wen, q_max_a, busy, done, err
  );

endinterface

// File: rtl/q_update_ctrl_argmax.sv
// Combinational 4-lane signed max with one-hot argmax; ties go to the lowest lane.
module q_update_ctrl_argmax
  import q_update_ctrl_pkg::*;
#(
  parameter int unsigned Q_WIDTH = QW_DEF
) (
  input  logic [Q_WIDTH*N_ACT-1:0] q_row,
  output logic signed [Q_WIDTH-1:0] q_max,
  output logic [N_ACT-1:0]         q_max_oh
);

  always_comb begin
    q_max    = $signed(q_row[Q_WIDTH-1:0]);
    q_max_oh = {{(N_ACT-1){1'b0}}, 1'b1};
    // Strict compare keeps the earliest lane on ties.
    for (int i = 1; i < int'(N_ACT); i++) begin
      if ($signed(q_row[i*Q_WIDTH +: Q_WIDTH]) > q_max) begin
        q_max       = $signed(q_row[i*Q_WIDTH +: Q_WIDTH]);
        q_max_oh    = '0;
        q_max_oh[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/q_update_ctrl.sv
// Sequences one Q-learning update: read Q(s,.), read Q(s',.), form the
// saturated TD result and write Q(s,a) back through the MII port.
module q_update_ctrl
  import q_update_ctrl_pkg::*;
#(
  parameter int unsigned Q_WIDTH     = QW_DEF,
  parameter int unsigned S_WIDTH     = SW_DEF,
  parameter int unsigned A_WIDTH     = N_ACT,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned ALPHA_SHIFT = 2,
  parameter int unsigned GAMMA_SHIFT = 1
) (
  input  logic           clk,
  input  logic           rst,
  q_update_ctrl_if.slave bus
);

  localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned XW   = Q_WIDTH + GUARD_BITS;
  localparam logic signed [XW-1:0] QMaxX = XW'((1 << (Q_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] QMinX = ~QMaxX;

  state_e state_q, state_d;

  logic [CntW-1:0]           cnt_q;
  logic                      cnt_last;
  logic [S_WIDTH-1:0]        s_cur_q, s_nxt_q;
  logic [A_WIDTH-1:0]        a_q;
  logic signed [Q_WIDTH-1:0] r_q, qc_q, qmax_q;
  logic [A_WIDTH-1:0]        qmax_a_q;
  logic [S_WIDTH-1:0]        mem_s_q;
  logic [A_WIDTH-1:0]        mem_a_q;
  logic [Q_WIDTH-1:0]        mem_qnew_q;
  logic                      err_q;

  logic                      a_ok;
  logic signed [Q_WIDTH-1:0] qc_sel;
  logic signed [Q_WIDTH-1:0] row_max;
  logic [N_ACT-1:0]          row_max_oh;
  logic signed [XW-1:0]      r_x, qc_x, qm_x, target, td_err, q_x;
  logic signed [Q_WIDTH-1:0] q_sat;

  assign a_ok     = $onehot(bus.a_cur);
  assign cnt_last = (cnt_q == CntW'(RD_LAT - 1));

  q_update_ctrl_argmax #(
    .Q_WIDTH (Q_WIDTH)
  ) u_argmax (
    .q_row    (bus.mem_Q),
    .q_max    (row_max),
    .q_max_oh (row_max_oh)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start && a_ok) state_d = StRdCur;
      StRdCur: if (cnt_last) state_d = StRdNxt;
      StRdNxt: if (cnt_last) state_d = StCalc;
      StCalc:  state_d = StWr;
      StWr:    state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy    = (state_q != StIdle);
    bus.mem_wen = (state_q == StWr);
    bus.done    = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if ((state_q == StRdCur) || (state_q == StRdNxt)) begin
      cnt_q <= cnt_last ? '0 : cnt_q + CntW'(1);
    end
  end

  // Q(s,a) lane picked by the captured one-hot action.
  always_comb begin
    qc_sel = '0;
    for (int i = 0; i < int'(A_WIDTH); i++) begin
      if (a_q[i]) qc_sel = $signed(bus.mem_Q[i*Q_WIDTH +: Q_WIDTH]);
    end
  end

  always_comb begin
    r_x    = XW'(r_q);
    qc_x   = XW'(qc_q);
    qm_x   = XW'(qmax_q);
    target = r_x + (qm_x >>> GAMMA_SHIFT);
    td_err = target - qc_x;
    q_x    = qc_x + (td_err >>> ALPHA_SHIFT);
    if (q_x > QMaxX) begin
      q_sat = QMaxX[Q_WIDTH-1:0];
    end else if (q_x < QMinX) begin
      q_sat = QMinX[Q_WIDTH-1:0];
    end else begin
      q_sat = q_x[Q_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cur_q    <= '0;
      s_nxt_q    <= '0;
      a_q        <= '0;
      r_q        <= '0;
      qc_q       <= '0;
      qmax_q     <= '0;
      qmax_a_q   <= '0;
      mem_s_q    <= '0;
      mem_a_q    <= '0;
      mem_qnew_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start && a_ok) begin
            s_cur_q <= bus.s_cur;
            s_nxt_q <= bus.s_nxt;
            a_q     <= bus.a_cur;
            r_q     <= bus.reward;
            mem_s_q <= bus.s_cur;
            mem_a_q <= '0;
          end else if (bus.start) begin
            err_q <= 1'b1;
          end
        end
        StRdCur: begin
          if (cnt_last) begin
            qc_q    <= qc_sel;
            mem_s_q <= s_nxt_q;
          end
        end
        StRdNxt: begin
          if (cnt_last) begin
            qmax_q   <= row_max;
            qmax_a_q <= row_max_oh;
          end
        end
        StCalc: begin
          mem_qnew_q <= q_sat;
          mem_s_q    <= s_cur_q;
          mem_a_q    <= a_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_S    = mem_s_q;
  assign bus.mem_A    = mem_a_q;
  assign bus.mem_Qnew = mem_qnew_q;
  assign bus.q_max_a  = qmax_a_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_q_update_ctrl.sv
// Scoreboard bench for q_update_ctrl: directed updates push expected writes,
// a negedge monitor checks every mem_wen against the queue.
module tb_q_update_ctrl;

  typedef struct packed {
    logic [15:0] q;
    logic [11:0] s;
    logic [3:0]  a;
    logic [3:0]  amax;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   wen_cnt  = 0;
  exp_t sbq[$];
  logic [63:0] rows [4096];
  logic [15:0] lfsr = 16'hACE1;

  q_update_ctrl_if bus_if ();

  q_update_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read port model: row appears one edge after mem_S changes.
  always @(posedge clk) bus_if.mem_Q <= rows[bus_if.mem_S];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_if.done) done_cnt++;
    if (bus_if.mem_wen) begin
      wen_cnt++;
      if (sbq.size() == 0) begin
        chk("unexpected mem_wen", 64'(bus_if.mem_wen), 64'(0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("mem_Qnew", 64'(bus_if.mem_Qnew), 64'(e.q));
        chk("mem_S at write", 64'(bus_if.mem_S), 64'(e.s));
        chk("mem_A at write", 64'(bus_if.mem_A), 64'(e.a));
        chk("q_max_a", 64'(bus_if.q_max_a), 64'(e.amax));
      end
    end
  end

  function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  function automatic logic [19:0] ref_update(input logic signed [15:0] qc,
                                             input logic signed [15:0] r,
                                             input logic [63:0] row);
    int mx, idx, lane, t, e, q;
    mx  = int'($signed(row[15:0]));
    idx = 0;
    for (int i = 1; i < 4; i++) begin
      lane = int'($signed(row[i*16 +: 16]));
      if (lane > mx) begin
        mx  = lane;
        idx = i;
      end
    end
    t = int'(r) + (mx >>> 1);
    e = t - int'(qc);
    q = int'(qc) + (e >>> 2);
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return {4'(1 << idx), 16'(q)};
  endfunction

  function automatic logic [39:0] out_vec();
    return {bus_if.busy, bus_if.done, bus_if.mem_wen, bus_if.err, bus_if.mem_S,
            bus_if.mem_A, bus_if.mem_Qnew, bus_if.q_max_a};
  endfunction

  task automatic drive_start(input logic [11:0] s, input logic [11:0] sn,
                             input logic [3:0] a, input logic [15:0] r);
    @(negedge clk);
    bus_if.s_cur  = s;
    bus_if.s_nxt  = sn;
    bus_if.a_cur  = a;
    bus_if.reward = r;
    bus_if.start  = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start  = 1'b0;
    // Later input changes must not reach the update in flight.
    bus_if.s_cur  = 12'hFFF;
    bus_if.s_nxt  = 12'hFFE;
    bus_if.a_cur  = 4'b1000;
    bus_if.reward = 16'h7000;
  endtask

  task automatic run_update(input string name, input logic [11:0] s, input logic [11:0] sn,
                            input logic [3:0] a, input logic [15:0] r,
                            input logic [63:0] row_s, input logic [63:0] row_sn,
                            input logic [15:0] eq, input logic [3:0] eamax, input bit overlap);
    int lat;
    int d0;
    rows[s]  = row_s;
    rows[sn] = row_sn;
    sbq.push_back('{q: eq, s: s, a: a, amax: eamax});
    d0 = done_cnt;
    drive_start(s, sn, a, r);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (overlap && k == 3) begin
        bus_if.a_cur = 4'b0001;
        bus_if.start = 1'b1;
      end
      if (overlap && k == 4) bus_if.start = 1'b0;
      if (bus_if.done) begin
        lat = k;
        break;
      end
    end
    chk({name, " latency"}, 64'(lat), 64'(7));
    repeat (3) @(negedge clk);
    chk({name, " done count"}, 64'(done_cnt - d0), 64'(1));
    chk({name, " idle after"}, 64'(bus_if.busy), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  inv [2];
    logic [63:0] rs, rn;
    logic [19:0] ex;
    logic [15:0] rr;
    int d0, w0, n;
    int tdone [3];

    for (int i = 0; i < 4096; i++) rows[i] = '0;
    bus_if.start  = 1'b0;
    bus_if.s_cur  = '0;
    bus_if.s_nxt  = '0;
    bus_if.a_cur  = '0;
    bus_if.reward = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2 chk("reset outputs", 64'(out_vec()), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle after reset", 64'(out_vec()), 64'(0));

    // Nominal, saturation both ways, negative error floor.
    run_update("nominal", 12'd5, 12'd9, 4'b0010, 16'd40, pk(7, 100, -3, 55),
               pk(10, -5, 64, 64), 16'd93, 4'b0100, 1'b0);
    run_update("sat pos", 12'd11, 12'd12, 4'b0001, 16'h7FFF, pk(32767, 0, 0, 0),
               pk(32767, 32767, 32767, 32767), 16'h7FFF, 4'b0001, 1'b0);
    run_update("sat neg", 12'd13, 12'd14, 4'b1000, 16'h8000, pk(0, 0, 0, -32768),
               pk(-32768, -32768, -32768, -32768), 16'h8000, 4'b0001, 1'b0);
    run_update("floor", 12'd15, 12'd16, 4'b0100, 16'hFFFF, pk(5, 5, 0, 5),
               pk(-3, 0, -7, 0), 16'hFFFF, 4'b0010, 1'b0);

    // Non-one-hot actions are rejected with a single err pulse.
    inv[0] = 4'b0110;
    inv[1] = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      d0 = done_cnt;
      w0 = wen_cnt;
      @(negedge clk);
      bus_if.a_cur = inv[i];
      bus_if.start = 1'b1;
      @(posedge clk);
      #1 bus_if.start = 1'b0;
      chk("err pulse", 64'(bus_if.err), 64'(1));
      chk("busy on reject", 64'(bus_if.busy), 64'(0));
      @(negedge clk);
      @(negedge clk);
      chk("err cleared", 64'(bus_if.err), 64'(0));
      repeat (10) @(negedge clk);
      chk("no done on reject", 64'(done_cnt - d0), 64'(0));
      chk("no wen on reject", 64'(wen_cnt - w0), 64'(0));
    end

    // Start during RD_NXT is ignored.
    run_update("overlap", 12'd20, 12'd21, 4'b0001, 16'd10, pk(-20, 1, 1, 1),
               pk(1, 2, 3, -8), 16'hFFF3, 4'b0100, 1'b1);

    // Reset during RD_NXT.
    rows[30] = pk(1, 2, 3, 4);
    rows[31] = pk(9, 9, 9, 9);
    sbq.push_back('{q: 16'd0, s: 12'd30, a: 4'b0001, amax: 4'b0001});
    d0 = done_cnt;
    w0 = wen_cnt;
    drive_start(12'd30, 12'd31, 4'b0001, 16'd3);
    repeat (3) @(negedge clk);
    chk("busy in RD_NXT", 64'(bus_if.busy), 64'(1));
    #2 rst = 1'b1;
    #1 chk("reset mid-op outputs", 64'(out_vec()), 64'(0));
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("no done after reset", 64'(done_cnt - d0), 64'(0));
    chk("no wen after reset", 64'(wen_cnt - w0), 64'(0));
    run_update("post reset", 12'd40, 12'd41, 4'b1000, 16'd0, pk(0, 0, 0, 200),
               pk(-100, -50, -60, -70), 16'h008F, 4'b0010, 1'b0);

    // Back-to-back with start held high.
    rows[50] = pk(0, 40, 0, 0);
    rows[51] = pk(8, 8, 8, 8);
    for (int i = 0; i < 3; i++) sbq.push_back('{q: 16'h0020, s: 12'd50, a: 4'b0010,
                                                  amax: 4'b0001});
    w0 = wen_cnt;
    n  = 0;
    @(negedge clk);
    bus_if.s_cur  = 12'd50;
    bus_if.s_nxt  = 12'd51;
    bus_if.a_cur  = 4'b0010;
    bus_if.reward = 16'd4;
    bus_if.start  = 1'b1;
    for (int k = 0; k < 60 && n < 3; k++) begin
      @(negedge clk);
      if (bus_if.done) begin
        tdone[n] = k;
        n++;
      end
    end
    bus_if.start = 1'b0;
    chk("b2b done count", 64'(n), 64'(3));
    chk("b2b period 1", 64'(tdone[1] - tdone[0]), 64'(8));
    chk("b2b period 2", 64'(tdone[2] - tdone[1]), 64'(8));
    repeat (10) @(negedge clk);
    chk("b2b wen count", 64'(wen_cnt - w0), 64'(3));
    chk("b2b queue drained", 64'(sbq.size()), 64'(0));

    // LFSR operands against the reference model.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] a;
      logic [15:0] lanes [4];
      for (int j = 0; j < 4; j++) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        lanes[j] = lfsr;
      end
      rs = {lanes[3], lanes[2], lanes[1], lanes[0]};
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      rn = {lfsr, ~lfsr, lfsr ^ 16'h5A5A, lfsr + 16'd77};
      rr = lfsr ^ 16'h3C3C;
      a  = 4'(1 << (i % 4));
      ex = ref_update($signed(rs[(i % 4)*16 +: 16]), $signed(rr), rn);
      run_update("random", 12'(100 + i), 12'(200 + i), a, rr, rs, rn, ex[15:0], ex[19:16],
                 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
